scanline_fx: RTL and testbench
==============================

# scanline_fx

Scanline post-processor placed directly after the scandoubler, clocked by its `ce_pix_out` (4x pixel enable). Darkens every odd output line by a selectable amount and forces blanked pixels to black. Delays vsync by one output line to resolve the scandoubler's outstanding vsync-alignment item. Feeds the video mixer and the HDMI/VGA output stage.

## Interface
- `HALF_DEPTH`, default 0: 1 selects 4-bit colour channels, 0 selects 8-bit (DWIDTH = 3 or 7).
- `clk_sys`  in  1  system clock; every register updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_pix`  in  1  pixel enable (scandoubler `ce_pix_out`); all state advances only when high.
- `scanlines`  in  2  0 = off, 1 = 25 % dim, 2 = 50 % dim, 3 = 75 % dim.
- `hs_in`, `vs_in`, `hb_in`, `vb_in`  in  1 each  active-high syncs and blanks from the scandoubler.
- `r_in`, `g_in`, `b_in`  in  DWIDTH+1 each  doubled pixel colour.
- `hs_out`, `vs_out`, `hb_out`, `vb_out`  out  1 each  syncs and blanks, pipeline-aligned.
- `r_out`, `g_out`, `b_out`  out  DWIDTH+1 each  processed colour.
- `line_odd`  out  1  current output-line parity, for debug and the mixer.

## Operation
- Stage 1 (at `ce_pix`): register all inputs into `s1_*`.
- Edge detection uses the previous `s1_hs` and `s1_vs` against the current inputs.
  - Line start = `hs_in` falling edge.
  - Frame start = `vs_in` rising edge.
- Parity counter `odd`:
  - Toggles at each line start.
  - Cleared to 0 at frame start. If both events occur on the same `ce_pix`, the clear wins and `odd` = 0.
- Mode latch `mode`:
  - Loaded from `scanlines` only at frame start.
  - Loaded at reset to the current `scanlines` value.
  - A mid-frame change to `scanlines` has no effect until the next frame start.
- Stage 2 (at `ce_pix`): compute per channel c from `s1_*`.
  - Blanked (`s1_hb | s1_vb`): output 0.
  - Otherwise, when `odd` = 0 or `mode` = 0: output c unchanged.
  - Otherwise, by `mode`:
    - mode 1 → c − (c >> 2)
    - mode 2 → c >> 1
    - mode 3 → c >> 2
  - All arithmetic is unsigned at channel width. Truncate; never round; no overflow is possible.
- Sync path:
  - `hs_out`, `hb_out`, `vb_out` are `s1_*` registered once more, so they are aligned with colour.
- Vsync one-line delay:
  - At line start: `vs_line <= vs_in`, and `vs_pend <= vs_line`.
  - `vs_out` takes `vs_pend` through the stage-2 register.
  - Net effect: `vs_out` edges move to the line start one line after the `vs_in` edge was sampled.
- `line_odd` mirrors the `odd` value used in stage 2.

## Timing
- Colour, `hs_out`, `hb_out`, `vb_out`: latency 2 `ce_pix` cycles.
- `vs_out` edge position relative to the `vs_in` edge:
  - If `vs_in` changes mid-line, it is sampled at the next line start and appears on `vs_out` at the line start after that, plus 2 `ce_pix`.
  - If `vs_in` changes on the same `ce_pix` as a line start, it is sampled immediately; `vs_out` changes one line later, plus 2 `ce_pix`.
- Outputs hold between `ce_pix` pulses. With `ce_pix` held low, nothing changes, including `odd` and `mode`.
- Reset (asynchronous, any time, including mid-line):
  - All outputs 0.
  - `odd` = 0; `vs_line` = `vs_pend` = 0; edge history = 0.
  - Video resumes on the second `ce_pix` after `reset_n` is released.
  - The first `ce_pix` after release with `vs_in` high counts as a frame start.
- `ce_pix` may be asserted on consecutive clocks (for example, when the master clock is 4x the pixel clock). There is no minimum gap.

## Test plan
- Pass-through: `scanlines` = 0, ramp r/g/b = 0x00..0xFF over 4 lines → output equals input delayed by 2 `ce_pix` on every line.
- Dim modes: constant input 0xC8, modes 1/2/3 latched at a frame start.
  - Even lines: 0xC8.
  - Odd lines: 0x96, 0x64, 0x32 respectively.
  - `HALF_DEPTH` = 1 with input 0xB: odd lines 0x9, 0x5, 0x2.
- Mode latch: switch `scanlines` 0→2 mid-frame → odd lines stay undimmed until after the next `vs_in` rise, then show c >> 1.
- Parity reset: assert the `vs_in` rise on the same `ce_pix` as an `hs_in` fall → `line_odd` = 0 on that line; the next line is odd.
- Vsync delay: assert the `vs_in` rise 100 `ce_pix` into line N → `vs_out` rises 2 `ce_pix` after the `hs_in` fall that starts line N+2. Falls symmetrically.
- Blank and reset: drive `hb_in`=1 with input 0xFF → output 0. Pulse `reset_n` low mid-line → all outputs 0 immediately, and `line_odd` = 0 afterwards.

Source files
------------

// File: rtl/scanline_fx.sv
// Scanline post-processor: dims odd output lines, forces blanked pixels black, delays vsync one line.
// Latency 2 ce_pix for colour/hs/hb/vb; no backpressure, everything advances only on ce_pix.
module scanline_fx #(
    parameter int HALF_DEPTH = 0,
    localparam int DWIDTH = (HALF_DEPTH != 0) ? 3 : 7
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [1:0]        scanlines,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              hb_in,
    input  logic              vb_in,
    input  logic [DWIDTH:0]   r_in,
    input  logic [DWIDTH:0]   g_in,
    input  logic [DWIDTH:0]   b_in,
    output logic              hs_out,
    output logic              vs_out,
    output logic              hb_out,
    output logic              vb_out,
    output logic [DWIDTH:0]   r_out,
    output logic [DWIDTH:0]   g_out,
    output logic [DWIDTH:0]   b_out,
    output logic              line_odd
);
    logic            s1_hs, s1_vs, s1_hb, s1_vb;
    logic [DWIDTH:0] s1_r, s1_g, s1_b;
    logic            odd, vs_line, vs_pend, arm;
    logic [1:0]      mode;
    logic            line_start, frame_start, blank;

    assign line_start  = s1_hs & ~hs_in;
    assign frame_start = vs_in & ~s1_vs;
    assign blank       = s1_hb | s1_vb;

    function automatic logic [DWIDTH:0] shade(input logic [DWIDTH:0] c, input logic blk,
                                              input logic dim_line, input logic [1:0] m);
        logic [DWIDTH:0] res;
        res = c;
        if (blk) begin
            res = '0;
        end else if (dim_line) begin
            case (m)
                2'd1:    res = c - (c >> 2);
                2'd2:    res = c >> 1;
                2'd3:    res = c >> 2;
                default: res = c;
            endcase
        end
        return res;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hb    <= 1'b0;
            s1_vb    <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            odd      <= 1'b0;
            vs_line  <= 1'b0;
            vs_pend  <= 1'b0;
            mode     <= 2'd0;
            arm      <= 1'b1;
            hs_out   <= 1'b0;
            vs_out   <= 1'b0;
            hb_out   <= 1'b0;
            vb_out   <= 1'b0;
            r_out    <= '0;
            g_out    <= '0;
            b_out    <= '0;
            line_odd <= 1'b0;
        end else if (ce_pix) begin
            s1_hs <= hs_in;
            s1_vs <= vs_in;
            s1_hb <= hb_in;
            s1_vb <= vb_in;
            s1_r  <= r_in;
            s1_g  <= g_in;
            s1_b  <= b_in;

            // Frame start beats a coincident line start so the first line of a frame is even.
            if (frame_start)
                odd <= 1'b0;
            else if (line_start)
                odd <= ~odd;

            // arm picks up the switch setting held through reset; it is consumed before any
            // dimmed pixel can reach the output, so it behaves as a load-at-reset.
            if (frame_start || arm)
                mode <= scanlines;
            arm <= 1'b0;

            if (line_start) begin
                vs_line <= vs_in;
                vs_pend <= vs_line;
            end

            hs_out   <= s1_hs;
            hb_out   <= s1_hb;
            vb_out   <= s1_vb;
            vs_out   <= vs_pend;
            line_odd <= odd;
            r_out    <= shade(s1_r, blank, odd && (mode != 2'd0), mode);
            g_out    <= shade(s1_g, blank, odd && (mode != 2'd0), mode);
            b_out    <= shade(s1_b, blank, odd && (mode != 2'd0), mode);
        end
    end
endmodule

// File: tb/tb_scanline_fx.sv
// Scoreboard bench for scanline_fx: 8-bit and 4-bit instances share syncs, expectations are hand values.
module tb_scanline_fx;
    logic       clk_sys = 1'b0;
    logic       reset_n, ce_pix;
    logic [1:0] scanlines;
    logic       hs_in, vs_in, hb_in, vb_in;
    logic [7:0] r_in, g_in, b_in;
    logic [3:0] h_in;
    logic       hs_out, vs_out, hb_out, vb_out, line_odd;
    logic [7:0] r_out, g_out, b_out;
    logic       h_hs, h_vs, h_hb, h_vb, h_odd;
    logic [3:0] h_r, h_g, h_b;

    always #5 clk_sys = ~clk_sys;

    scanline_fx #(.HALF_DEPTH(0)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_odd(line_odd));

    scanline_fx #(.HALF_DEPTH(1)) dut_h (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(h_in), .g_in(h_in), .b_in(h_in),
        .hs_out(h_hs), .vs_out(h_vs), .hb_out(h_hb), .vb_out(h_vb),
        .r_out(h_r), .g_out(h_g), .b_out(h_b), .line_odd(h_odd));

    typedef struct packed {
        logic        chk;
        logic [15:0] id;
        logic [7:0]  r, g, b;
        logic [3:0]  h;
        logic        hs, vs, hb, vb, odd;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          npix = 0;
    logic        cur_vs = 1'b0;
    logic [45:0] got;

    assign got = {r_out, g_out, b_out, h_r, h_g, h_b, hs_out, vs_out, hb_out, vb_out, line_odd,
                  h_hs, h_vs, h_hb, h_vb, h_odd};

    function automatic logic [45:0] want(input exp_t e);
        return {e.r, e.g, e.b, e.h, e.h, e.h, e.hs, e.vs, e.hb, e.vb, e.odd,
                e.hs, e.vs, e.hb, e.vb, e.odd};
    endfunction

    function automatic exp_t mk(input logic [7:0] r, g, b, input logic [3:0] h,
                                input logic hs, vs, hb, vb, odd);
        exp_t e;
        e.chk = 1'b1; e.id = 16'd0;
        e.r = r; e.g = g; e.b = b; e.h = h;
        e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.odd = odd;
        return e;
    endfunction

    task automatic compare(input logic [45:0] a, input logic [45:0] w, input string nm);
        checks++;
        if (a !== w) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, w);
        end
    endtask

    // Monitor: one pop per ce_pix edge; the entry popped belongs to the pixel one ce earlier.
    initial begin
        exp_t last;
        exp_t e;
        logic ce_seen;
        last = '0;
        last.chk = 1'b1;
        forever begin
            @(posedge clk_sys);
            ce_seen = ce_pix;
            @(negedge clk_sys);
            if (!reset_n) begin
                last = '0;
                last.chk = 1'b1;
                compare(got, '0, "reset");
            end else if (ce_seen) begin
                if (q.size() >= 2) begin
                    e = q.pop_front();
                    if (e.chk) compare(got, want(e), $sformatf("px%0d", e.id));
                    last = e;
                end
            end else if (last.chk) begin
                compare(got, want(last), "hold");
            end
        end
    end

    task automatic pix(input logic hs, vs, hb, vb, input logic [7:0] r, g, b, input exp_t e);
        hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
        ce_pix = 1'b1;
        e.id = npix[15:0];
        q.push_back(e);
        npix++;
        @(posedge clk_sys); #1;
        if (npix % 3 == 0) begin
            ce_pix = 1'b0;
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic tail(input logic eo, input logic evs, input logic vbv);
        repeat (2) pix(1'b1, cur_vs, 1'b1, vbv, 8'hAA, 8'hAA, 8'hAA,
                       mk(8'h00, 8'h00, 8'h00, 4'h0, 1'b1, evs, 1'b1, vbv, eo));
    endtask

    // act active pixels (first one is the hs fall) then a 2-pixel hsync tail.
    task automatic line(input int act, input bit ramp, input logic [7:0] cin, input int vs_at,
                        input logic vs_v, input int bl, input logic [7:0] ec1, ec2,
                        input logic [3:0] eh1, eh2, input logic eo1, eo2, input logic evs);
        for (int i = 0; i < act; i++) begin
            logic late, v;
            logic [7:0] r, g, b;
            exp_t e;
            late = (i >= vs_at);
            v = late ? vs_v : cur_vs;
            r = ramp ? 8'(cin + 8'(i)) : cin;
            g = ramp ? (r ^ 8'h5A) : cin;
            b = ramp ? ~r : cin;
            if (ramp)
                e = mk(r, g, b, late ? eh2 : eh1, 1'b0, evs, bl == 1, bl == 2, late ? eo2 : eo1);
            else
                e = mk(late ? ec2 : ec1, late ? ec2 : ec1, late ? ec2 : ec1, late ? eh2 : eh1,
                       1'b0, evs, bl == 1, bl == 2, late ? eo2 : eo1);
            if (bl != 0) begin
                e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; e.h = 4'h0;
            end
            pix(1'b0, v, bl == 1, bl == 2, r, g, b, e);
        end
        if (vs_at < act) cur_vs = vs_v;
        tail(eo2, evs, bl == 2);
    endtask

    task automatic do_reset(input logic [1:0] sl);
        #2;
        ce_pix = 1'b0;
        scanlines = sl;
        q.delete();
        q.push_back(mk(8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        exp_t d;
        reset_n = 1'b0; ce_pix = 1'b0; scanlines = 2'd0;
        hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00; h_in = 4'hB;
        q.push_back(mk(8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        // Pass-through ramp over four lines
        tail(1'b0, 1'b0, 1'b0);
        line(64, 1, 8'h00, 999, 1'b0, 0, 8'h00, 8'h00, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0);
        line(64, 1, 8'h40, 999, 1'b0, 0, 8'h00, 8'h00, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(64, 1, 8'h80, 999, 1'b0, 0, 8'h00, 8'h00, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0);
        line(64, 1, 8'hC0, 999, 1'b0, 0, 8'h00, 8'h00, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);

        // Dim modes; vs rise coincides with the hs fall (parity clear wins)
        scanlines = 2'd1;
        line(6, 0, 8'hC8, 0,   1'b1, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h96, 8'h96, 4'h9, 4'h9, 1'b1, 1'b1, 1'b1);
        line(6, 0, 8'hC8, 0,   1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h96, 8'h96, 4'h9, 4'h9, 1'b1, 1'b1, 1'b0);
        scanlines = 2'd2;
        line(6, 0, 8'hC8, 0,   1'b1, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h64, 8'h64, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1);
        line(6, 0, 8'hC8, 0,   1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h64, 8'h64, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
        scanlines = 2'd3;
        line(6, 0, 8'hC8, 0,   1'b1, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h32, 8'h32, 4'h2, 4'h2, 1'b1, 1'b1, 1'b1);
        line(6, 0, 8'hC8, 0,   1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h32, 8'h32, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0);

        // Mode latch: 0 -> 2 mid-frame only takes effect after the next vs rise
        scanlines = 2'd0;
        line(6, 0, 8'hC8, 0,   1'b1, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b1, 1'b1, 1'b1);
        scanlines = 2'd2;
        line(6, 0, 8'hC8, 0,   1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0);
        line(6, 0, 8'hC8, 0,   1'b1, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h64, 8'h64, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1);
        line(6, 0, 8'hC8, 0,   1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);

        // Vsync delay: edges 100 pixels into a line reach vs_out at the start of line N+2
        scanlines = 2'd0;
        line(108, 0, 8'hC8, 100, 1'b1, 0, 8'h64, 8'hC8, 4'h5, 4'hB, 1'b1, 1'b0, 1'b0);
        line(6,   0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0);
        line(6,   0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(108, 0, 8'hC8, 100, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b1, 1'b1, 1'b1);
        line(6,   0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b1);
        line(6,   0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b1, 1'b1, 1'b0);

        // Blanking forces black
        line(6, 0, 8'hFF, 999, 1'b0, 1, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hFF, 999, 1'b0, 2, 8'h00, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Mid-line reset; mode 3 is picked up from the switch held through reset
        repeat (3) pix(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8, 8'hC8, 8'hC8,
                       mk(8'hC8, 8'hC8, 8'hC8, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset(2'd3);
        tail(1'b0, 1'b0, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'h32, 8'h32, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
        line(6, 0, 8'hC8, 999, 1'b0, 0, 8'hC8, 8'hC8, 4'hB, 4'hB, 1'b0, 1'b0, 1'b0);

        d = '0;
        pix(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, d);
        ce_pix = 1'b0;
        repeat (4) @(posedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
